// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF sequencer.
package ro_puf_pkg;

    localparam int unsigned CHAL_PER_BIT = 6;
    localparam int unsigned SEL_W        = 3;
    localparam int unsigned BX_W         = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        SETTLE,
        SAMPLE,
        COMPARE,
        DONE
    } state_t;

    typedef enum logic {
        PH_A,
        PH_B
    } phase_t;

    // Largest of three cycle counts; sizes the shared phase timer.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ro_gate_timer.sv
// Loadable down-counter with a registered zero flag; stops at zero, never wraps.
module ro_gate_timer #(
    parameter int unsigned TW = 17
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic          zero_o
);

    logic [TW-1:0] cnt_q;
    logic          zero_q;

    // Load on request, otherwise count down and flag the last cycle.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else if (load_i) begin
            cnt_q  <= load_val_i;
            zero_q <= (load_val_i == '0);
        end else if (cnt_q != '0) begin
            cnt_q  <= cnt_q - TW'(1);
            zero_q <= (cnt_q == TW'(1));
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/ro_puf_sequencer.sv
// Sequences A/B ring-oscillator measurements per challenge bit and builds the response word.
module ro_puf_sequencer
    import ro_puf_pkg::*;
#(
    parameter int unsigned N_BITS     = 8,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned GATE_CYC   = 100000,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned CLR_CYC    = 2
) (
    input  logic                           CLK,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [N_BITS*CHAL_PER_BIT-1:0] challenge,
    input  logic [BX_W-1:0]                bx,
    input  logic [CNT_W-1:0]               ro_cnt,
    input  logic                           ro_cnt_sat,
    output logic                           ro_en,
    output logic [SEL_W-1:0]               ro_sel,
    output logic [BX_W-1:0]                ro_bx,
    output logic                           ro_cnt_rst,
    output logic                           busy,
    output logic                           done,
    output logic [N_BITS-1:0]              response,
    output logic [CNT_W-1:0]               last_cnt_a,
    output logic [CNT_W-1:0]               last_cnt_b,
    output logic                           sat_err,
    output logic [$clog2(N_BITS+1)-1:0]    tie_cnt
);

    localparam int unsigned CHAL_W     = N_BITS * CHAL_PER_BIT;
    localparam int unsigned CHAL_IDX_W = $clog2(CHAL_W);
    localparam int unsigned IDX_W      = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int unsigned TIE_W      = $clog2(N_BITS + 1);
    localparam int unsigned TMR_MAX    = max3(GATE_CYC, SETTLE_CYC, CLR_CYC);
    localparam int unsigned TMR_W      = $clog2(TMR_MAX + 1);

    state_t state_q, state_d;

    logic [CHAL_W-1:0] chal_q, chal_d;
    logic [BX_W-1:0]   bx_q, bx_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    phase_t            phase_q, phase_d;
    logic [N_BITS-1:0] resp_q, resp_d;
    logic [CNT_W-1:0]  last_a_q, last_a_d;
    logic [CNT_W-1:0]  last_b_q, last_b_d;
    logic              sat_q, sat_d;
    logic [TIE_W-1:0]  tie_q, tie_d;

    logic                  ro_en_q, ro_cnt_rst_q, busy_q, done_q;
    logic [SEL_W-1:0]      ro_sel_q;
    logic [BX_W-1:0]       ro_bx_q;

    logic                  tmr_load;
    logic [TMR_W-1:0]      tmr_val;
    logic                  tmr_zero;
    logic                  last_bit;
    logic [CHAL_IDX_W-1:0] sel_base;
    logic [SEL_W-1:0]      sel_d;

    assign last_bit = (idx_q == IDX_W'(N_BITS - 1));

    ro_gate_timer #(
        .TW (TMR_W)
    ) u_timer (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, plus timer reload with the dwell of the state being entered.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            IDLE:    if (start) state_d = CLR;
            CLR:     if (tmr_zero) state_d = RUN;
            RUN:     if (tmr_zero) state_d = SETTLE;
            SETTLE:  if (tmr_zero) state_d = SAMPLE;
            SAMPLE:  state_d = (phase_q == PH_A) ? CLR : COMPARE;
            COMPARE: state_d = last_bit ? DONE : CLR;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        tmr_load = (state_d != state_q);
        case (state_d)
            CLR:     tmr_val = TMR_W'(CLR_CYC - 1);
            RUN:     tmr_val = TMR_W'(GATE_CYC - 1);
            SETTLE:  tmr_val = TMR_W'(SETTLE_CYC - 1);
            default: tmr_val = '0;
        endcase
    end

    // Challenge latch, sampling, comparison and the select for the upcoming measurement.
    always_comb begin
        chal_d   = chal_q;
        bx_d     = bx_q;
        idx_d    = idx_q;
        phase_d  = phase_q;
        resp_d   = resp_q;
        last_a_d = last_a_q;
        last_b_d = last_b_q;
        sat_d    = sat_q;
        tie_d    = tie_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    chal_d  = challenge;
                    bx_d    = bx;
                    idx_d   = '0;
                    phase_d = PH_A;
                    resp_d  = '0;
                    sat_d   = 1'b0;
                    tie_d   = '0;
                end
            end
            SAMPLE: begin
                if (phase_q == PH_A) begin
                    last_a_d = ro_cnt;
                    phase_d  = PH_B;
                end else begin
                    last_b_d = ro_cnt;
                end
                if (ro_cnt_sat) sat_d = 1'b1;
            end
            COMPARE: begin
                resp_d[idx_q] = (last_a_q > last_b_q);
                if (last_a_q == last_b_q) tie_d = tie_q + TIE_W'(1);
                if (!last_bit) begin
                    idx_d   = idx_q + IDX_W'(1);
                    phase_d = PH_A;
                end
            end
            default: ;
        endcase
        sel_base = CHAL_IDX_W'(CHAL_PER_BIT * 32'(idx_d) + ((phase_d == PH_B) ? SEL_W : 0));
        sel_d    = chal_d[sel_base +: SEL_W];
    end

    // Datapath registers.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            chal_q   <= '0;
            bx_q     <= '0;
            idx_q    <= '0;
            phase_q  <= PH_A;
            resp_q   <= '0;
            last_a_q <= '0;
            last_b_q <= '0;
            sat_q    <= 1'b0;
            tie_q    <= '0;
        end else begin
            chal_q   <= chal_d;
            bx_q     <= bx_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            resp_q   <= resp_d;
            last_a_q <= last_a_d;
            last_b_q <= last_b_d;
            sat_q    <= sat_d;
            tie_q    <= tie_d;
        end
    end

    // Registered RO controls and status, decoded from the state being entered.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            ro_en_q      <= 1'b0;
            ro_cnt_rst_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ro_sel_q     <= '0;
            ro_bx_q      <= '0;
        end else begin
            ro_en_q      <= (state_d == RUN);
            ro_cnt_rst_q <= (state_d == IDLE) || (state_d == CLR);
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == DONE);
            if (state_d == CLR) begin
                ro_sel_q <= sel_d;
                ro_bx_q  <= bx_d;
            end
        end
    end

    assign ro_en      = ro_en_q;
    assign ro_sel     = ro_sel_q;
    assign ro_bx      = ro_bx_q;
    assign ro_cnt_rst = ro_cnt_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign response   = resp_q;
    assign last_cnt_a = last_a_q;
    assign last_cnt_b = last_b_q;
    assign sat_err    = sat_q;
    assign tie_cnt    = tie_q;

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Directed bench for ro_puf_sequencer with a behavioural RO + counter model.
module tb_ro_puf_sequencer;

    localparam int unsigned N_BITS     = 4;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned GATE_CYC   = 10;
    localparam int unsigned SETTLE_CYC = 3;
    localparam int unsigned CLR_CYC    = 2;
    localparam int unsigned CW         = N_BITS * 6;
    localparam int unsigned TIE_W      = $clog2(N_BITS + 1);
    localparam int          LATENCY    = 133;

    logic              CLK;
    logic              rst_n;
    logic              start;
    logic [CW-1:0]     challenge;
    logic [2:0]        bx;
    logic [CNT_W-1:0]  ro_cnt;
    logic              ro_cnt_sat;
    logic              ro_en;
    logic [2:0]        ro_sel;
    logic [2:0]        ro_bx;
    logic              ro_cnt_rst;
    logic              busy;
    logic              done;
    logic [N_BITS-1:0] response;
    logic [CNT_W-1:0]  last_cnt_a;
    logic [CNT_W-1:0]  last_cnt_b;
    logic              sat_err;
    logic [TIE_W-1:0]  tie_cnt;
    logic              sat_force;

    int n_checks = 0;
    int n_errors = 0;

    ro_puf_sequencer #(
        .N_BITS     (N_BITS),
        .CNT_W      (CNT_W),
        .GATE_CYC   (GATE_CYC),
        .SETTLE_CYC (SETTLE_CYC),
        .CLR_CYC    (CLR_CYC)
    ) dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .start      (start),
        .challenge  (challenge),
        .bx         (bx),
        .ro_cnt     (ro_cnt),
        .ro_cnt_sat (ro_cnt_sat),
        .ro_en      (ro_en),
        .ro_sel     (ro_sel),
        .ro_bx      (ro_bx),
        .ro_cnt_rst (ro_cnt_rst),
        .busy       (busy),
        .done       (done),
        .response   (response),
        .last_cnt_a (last_cnt_a),
        .last_cnt_b (last_cnt_b),
        .sat_err    (sat_err),
        .tie_cnt    (tie_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [CNT_W-1:0] rate(input logic [2:0] sel);
        case (sel)
            3'd0: return 16'd5;
            3'd1: return 16'd3;
            3'd2: return 16'd7;
            3'd3: return 16'd2;
            3'd4: return 16'd4;
            3'd5: return 16'd4;
            3'd6: return 16'd6;
            default: return 16'd1;
        endcase
    endfunction

    // RO + edge counter model.
    always @(posedge CLK) begin
        if (ro_cnt_rst) ro_cnt <= '0;
        else if (ro_en) ro_cnt <= ro_cnt + rate(ro_sel);
    end
    assign ro_cnt_sat = sat_force;

    function automatic logic [5:0] enc(input logic [2:0] a, input logic [2:0] b);
        return {b, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Issue one challenge and follow it to the cycle after done.
    task automatic run_chal(input logic [CW-1:0] chal, input logic [2:0] bxv,
                            input logic [CW-1:0] alt, input int glitch_at,
                            input int sat_meas, output int lat, output int ndone);
        int en_len, meas, busy_bad, sel_bad, bx_bad, rst_bad;
        logic [2:0] sel_run;
        en_len = 0; meas = 0; busy_bad = 0; sel_bad = 0; bx_bad = 0; rst_bad = 0;
        sel_run = '0; lat = 0; ndone = 0;
        challenge = chal;
        bx = bxv;
        start = 1'b1;
        tick();
        for (int t = 1; t <= 400; t++) begin
            start = 1'b0;
            if (lat != 0) begin
                check("busy_drop", 32'(busy), 32'd0);
                check("done_width", 32'(done), 32'd0);
                break;
            end
            if (!busy) busy_bad++;
            if (done) begin
                ndone++;
                lat = t;
            end
            if (ro_en) begin
                if (en_len == 0) sel_run = ro_sel;
                else if (ro_sel !== sel_run) sel_bad++;
                if (ro_bx !== bxv) bx_bad++;
                if (ro_cnt_rst) rst_bad++;
                en_len++;
            end else if (en_len != 0) begin
                check("gate_len", 32'(en_len), GATE_CYC);
                if (meas == sat_meas) sat_force = 1'b1;
                meas++;
                en_len = 0;
            end
            if (sat_force && ro_cnt_rst) sat_force = 1'b0;
            if (t == glitch_at) begin
                start = 1'b1;
                challenge = alt;
            end
            tick();
        end
        start = 1'b0;
        sat_force = 1'b0;
        check("meas_count", 32'(meas), 2 * N_BITS);
        check("busy_held", 32'(busy_bad), 32'd0);
        check("sel_stable", 32'(sel_bad), 32'd0);
        check("bx_held", 32'(bx_bad), 32'd0);
        check("rst_during_en", 32'(rst_bad), 32'd0);
    endtask

    logic [CW-1:0] chal_basic, chal_full, chal_tie, chal_alt;
    int lat, nd;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        challenge = '0;
        bx = '0;
        sat_force = 1'b0;
        chal_basic = {4{enc(3'd0, 3'd1)}};
        chal_full  = {enc(3'd0, 3'd4), enc(3'd7, 3'd3), enc(3'd2, 3'd6), enc(3'd1, 3'd2)};
        chal_tie   = {enc(3'd0, 3'd1), enc(3'd0, 3'd1), enc(3'd0, 3'd1), enc(3'd4, 3'd5)};
        chal_alt   = {4{enc(3'd1, 3'd0)}};
        repeat (3) tick();

        check("rst_ro_en", 32'(ro_en), 32'd0);
        check("rst_ro_cnt_rst", 32'(ro_cnt_rst), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ro_sel", 32'(ro_sel), 32'd0);
        check("rst_ro_bx", 32'(ro_bx), 32'd0);
        check("rst_response", 32'(response), 32'd0);
        check("rst_last_a", 32'(last_cnt_a), 32'd0);
        check("rst_last_b", 32'(last_cnt_b), 32'd0);
        check("rst_sat", 32'(sat_err), 32'd0);
        check("rst_tie", 32'(tie_cnt), 32'd0);

        rst_n = 1'b1;
        tick();

        // Basic: sel 0 vs sel 1 on every bit.
        run_chal(chal_basic, 3'd5, '0, -1, -1, lat, nd);
        check("basic_latency", 32'(lat), LATENCY);
        check("basic_done_cnt", 32'(nd), 32'd1);
        check("basic_response", 32'(response), 32'hF);
        check("basic_last_a", 32'(last_cnt_a), 32'd50);
        check("basic_last_b", 32'(last_cnt_b), 32'd30);
        check("basic_tie", 32'(tie_cnt), 32'd0);
        check("basic_sat", 32'(sat_err), 32'd0);

        // Full word with a start glitch while busy carrying a different challenge.
        run_chal(chal_full, 3'd2, chal_alt, 40, -1, lat, nd);
        check("full_latency", 32'(lat), LATENCY);
        check("full_done_cnt", 32'(nd), 32'd1);
        check("full_response", 32'(response), 32'hA);
        check("full_last_a", 32'(last_cnt_a), 32'd50);
        check("full_last_b", 32'(last_cnt_b), 32'd40);
        check("full_tie", 32'(tie_cnt), 32'd0);
        check("idle_after_glitch", 32'(busy), 32'd0);

        // Saturation flagged during the bit-0 B sample only.
        run_chal(chal_full, 3'd7, '0, -1, 1, lat, nd);
        check("sat_latency", 32'(lat), LATENCY);
        check("sat_err", 32'(sat_err), 32'd1);
        check("sat_response", 32'(response), 32'hA);

        // Tie on bit 0; sat_err must clear on the new start.
        run_chal(chal_tie, 3'd1, '0, -1, -1, lat, nd);
        check("tie_latency", 32'(lat), LATENCY);
        check("tie_response", 32'(response), 32'hE);
        check("tie_cnt", 32'(tie_cnt), 32'd1);
        check("tie_sat_clear", 32'(sat_err), 32'd0);
        check("tie_last_a", 32'(last_cnt_a), 32'd50);
        check("tie_last_b", 32'(last_cnt_b), 32'd30);

        // Reset and start in the same cycle: reset wins.
        rst_n = 1'b0;
        start = 1'b1;
        challenge = chal_basic;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        check("rststart_busy", 32'(busy), 32'd0);
        check("rststart_response", 32'(response), 32'd0);
        tick();
        check("rststart_idle", 32'(busy), 32'd0);
        check("rststart_cnt_rst", 32'(ro_cnt_rst), 32'd1);

        // Reset in the middle of RUN.
        challenge = chal_full;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && !ro_en; i++) tick();
        check("midrst_reach_run", 32'(ro_en), 32'd1);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_ro_en", 32'(ro_en), 32'd0);
        check("midrst_cnt_rst", 32'(ro_cnt_rst), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        nd = 0;
        for (int i = 0; i < 200; i++) begin
            if (done || busy) nd++;
            tick();
        end
        check("midrst_no_done", 32'(nd), 32'd0);

        // Recovery after the aborted challenge.
        run_chal(chal_full, 3'd3, '0, -1, -1, lat, nd);
        check("recover_latency", 32'(lat), LATENCY);
        check("recover_done_cnt", 32'(nd), 32'd1);
        check("recover_response", 32'(response), 32'hA);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ro_puf_sequencer.md
Name: ro_puf_sequencer

Overview:
- Sequences ring-oscillator (RO) frequency measurements to produce an N_BITS PUF response word.
- For each response bit, one RO configuration (A) is enabled, its edge counter is cleared, the RO runs for a fixed gate window, and the count is sampled. The same is then done for configuration B, and the two counts are compared.
- Drives the RO enable/select/bx inputs and the counter reset, and reads the counter value and saturation flag.
- Sits between switch/host control and the RO + counter datapath. The last counts are exported for the seven-segment display.

Parameters:
- N_BITS, 8, number of response bits per challenge.
- CNT_W, 16, width of the RO counter value input.
- GATE_CYC, 100000, CLK cycles the RO is enabled per measurement. Must be >= 1.
- SETTLE_CYC, 4, CLK cycles after disable before sampling. Must be >= 2; this makes the counter value stable before sampling, so no synchronizer is needed.
- CLR_CYC, 2, CLK cycles the counter reset is held.

Ports:
- CLK  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle request to begin a challenge
- challenge  in  N_BITS*6  bits[6i+2:6i] = sel_a for bit i; bits[6i+5:6i+3] = sel_b for bit i
- bx  in  3  bx setting applied to all measurements; latched at start
- ro_cnt  in  CNT_W  RO counter value
- ro_cnt_sat  in  1  counter at_max flag
- ro_en  out  1  RO enable
- ro_sel  out  3  RO select
- ro_bx  out  3  RO bx config
- ro_cnt_rst  out  1  counter reset, active high
- busy  out  1  high from the cycle after an accepted start through the DONE state
- done  out  1  one-cycle pulse when the response is valid
- response  out  N_BITS  result word; bit i = 1 iff cnt_a(i) > cnt_b(i)
- last_cnt_a  out  CNT_W  most recent A count
- last_cnt_b  out  CNT_W  most recent B count
- sat_err  out  1  sticky per challenge; set if any sample sees ro_cnt_sat
- tie_cnt  out  $clog2(N_BITS+1)  number of bits with cnt_a == cnt_b

Behaviour:
- Reset (rst_n = 0 at a CLK edge): state = IDLE; all outputs 0, except ro_cnt_rst = 1.
- FSM states: IDLE -> CLR -> RUN -> SETTLE -> SAMPLE -> (CLR for B, or COMPARE) -> (CLR for the next bit, or DONE) -> IDLE.
- IDLE:
  - start = 1 latches challenge and bx; clears response, sat_err and tie_cnt; sets bit index = 0 and phase = A; next state CLR.
  - start while not in IDLE is ignored.
- CLR:
  - ro_cnt_rst = 1, ro_en = 0.
  - ro_sel = sel_a or sel_b of the current bit, chosen by phase; ro_bx = latched bx.
  - ro_sel/ro_bx stay held through RUN, SETTLE and SAMPLE.
  - After CLR_CYC cycles -> RUN.
- RUN: ro_en = 1, ro_cnt_rst = 0, for exactly GATE_CYC cycles -> SETTLE.
- SETTLE: ro_en = 0 for SETTLE_CYC cycles -> SAMPLE.
- SAMPLE (1 cycle):
  - Capture ro_cnt into last_cnt_a (phase A) or last_cnt_b (phase B).
  - If ro_cnt_sat = 1, set sat_err.
  - Phase A: phase <= B, next CLR. Phase B: next COMPARE.
- COMPARE (1 cycle):
  - response[index] <= (last_cnt_a > last_cnt_b), unsigned compare.
  - If the counts are equal, the bit is 0 and tie_cnt increments.
  - If index == N_BITS-1 -> DONE; otherwise index++, phase = A, next CLR.
- DONE (1 cycle): done = 1, then -> IDLE. busy drops in the IDLE cycle.
- response, last_cnt_*, sat_err and tie_cnt hold their values until the next accepted start.
- Latency from start to done = 1 + N_BITS*(2*(CLR_CYC + GATE_CYC + SETTLE_CYC + 1) + 1) cycles.
- Gate and settle counters are $clog2(GATE_CYC+1) bits wide, reload on each state entry, and must not wrap.
- Reset mid-operation: ro_en drops in the same cycle, the FSM returns to IDLE, and no done pulse is issued.
- start asserted in the same cycle as rst_n = 0: reset wins.

Decomposition:
- Package ro_puf_pkg holds:
  - typedef enum state_t {IDLE, CLR, RUN, SETTLE, SAMPLE, COMPARE, DONE};
  - typedef enum phase_t {PH_A, PH_B};
  - localparam CHAL_PER_BIT = 6.
- One sub-module, ro_gate_timer: a loadable down-counter with load value and a zero flag, shared across the CLR, RUN and SETTLE states.

Test Plan:
- Test parameters: GATE_CYC = 10, SETTLE_CYC = 3, CLR_CYC = 2, N_BITS = 4.
- The bench RO model increments ro_cnt by rate[ro_sel] per CLK while ro_en = 1, and clears it on ro_cnt_rst.
- Basic: rate = {0:5, 1:3, …}, challenge bit0 = (sel_a 0, sel_b 1) -> last_cnt_a = 50, last_cnt_b = 30, response[0] = 1.
- Full word:
  - Challenge chosen so the A/B rates yield expected response 4'b1010.
  - Check: done pulses exactly once at cycle 1 + 4*(2*16 + 1) = 133 after start; busy stays high throughout.
- Tie: equal rates on both selects -> bit = 0 and tie_cnt = 1.
- Saturation: force ro_cnt_sat = 1 during one SAMPLE -> sat_err = 1 at done; response still computed.
- Protocol: start pulsed while busy -> ignored and latched challenge unchanged. rst_n low during RUN -> next cycle ro_en = 0, ro_cnt_rst = 1, busy = 0, and no done pulse.
- Gate width: count ro_en high cycles per measurement = exactly 10; ro_sel is stable whenever ro_en = 1.
